// File: rtl/replica_pkg.sv
// Shared types for the replica shift-chain: tour entry, chain command and the
// host I/O endpoint state encoding.
package replica_pkg;

   localparam int city_num = 8;

   typedef logic [15:0] replica_data;

   typedef enum logic [1:0] {
      NOP      = 2'd0,
      EXCHANGE = 2'd1,
      HOLD     = 2'd2,
      SCAN     = 2'd3
   } replica_command;

   typedef enum logic [2:0] {
      IO_IDLE,
      IO_LOAD,
      IO_ISSUE,
      IO_SHIFT,
      IO_DRAIN
   } replica_io_state;

endpackage

// File: rtl/replica_stream_io_if.sv
// One valid/ready stream of replica_data words.
// A word transfers on a rising clk edge where valid and ready are both high;
// the master holds valid and data stable until that edge.
interface replica_stream_io_if;

   logic                     valid;
   logic                     ready;
   replica_pkg::replica_data data;

   modport master (output valid, output data, input ready);
   modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/replica_io_buf.sv
// One-tour buffer: NUM entries, one synchronous write port and one registered
// read port (rdata reflects raddr from the previous cycle).
module replica_io_buf
   import replica_pkg::*;
#(
   parameter int NUM = city_num,
   parameter int AW  = $clog2(NUM + 2)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  replica_data   wdata,
   input  logic [AW-1:0] raddr,
   output replica_data   rdata
);

   localparam int IW = $clog2(NUM);

   replica_data mem [NUM];

   always_ff @(posedge clk) begin
      if (we) mem[waddr[IW-1:0]] <= wdata;
      rdata <= mem[raddr[IW-1:0]];
   end

endmodule

// File: rtl/replica_stream_io.sv
// Host-side endpoint of the replica chain: buffers a tour from the host,
// pulses one command, shifts the tour through the chain and returns the result.
module replica_stream_io
   import replica_pkg::*;
#(
   parameter  int NUM = city_num,
   localparam int CW  = $clog2(NUM + 2)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  replica_command      cmd_sel,
   replica_stream_io_if.slave  s,
   replica_stream_io_if.master m,
   output replica_command      command,
   output replica_data         prev_data,
   input  replica_data         chain_out,
   output logic                busy,
   output logic                done,
   output replica_io_state     state
);

   logic [CW-1:0]  k;
   replica_command cmd_q;
   logic           s_ready_q;
   logic           m_valid_q;
   logic           m_hs;
   logic           in_window;

   logic           buf_we;
   logic [CW-1:0]  buf_waddr;
   logic [CW-1:0]  buf_raddr;
   replica_data    buf_wdata;
   replica_data    buf_rdata;

   assign s.ready   = s_ready_q;
   assign m.valid   = m_valid_q;
   assign m.data    = m_valid_q ? buf_rdata : '0;
   assign m_hs      = m_valid_q & m.ready;
   assign done      = m_hs & (k == CW'(NUM - 1));
   assign busy      = (state != IO_IDLE);

   // SHIFT count c is cycle t0+1+c; entry c-1 meets the chain while c is 1..NUM.
   assign in_window = (state == IO_SHIFT) && (k >= CW'(1)) && (k <= CW'(NUM));
   assign prev_data = in_window ? buf_rdata : '0;

   always_comb begin
      buf_we    = 1'b0;
      buf_waddr = '0;
      buf_wdata = '0;
      buf_raddr = '0;
      case (state)
         IO_LOAD: begin
            buf_we    = s.valid & s_ready_q;
            buf_waddr = k;
            buf_wdata = s.data;
         end
         IO_SHIFT: begin
            buf_we    = in_window;
            buf_waddr = k - CW'(1);
            buf_wdata = chain_out;
            buf_raddr = (k < CW'(NUM)) ? k : '0;
         end
         IO_DRAIN: begin
            if (m_hs) buf_raddr = (k == CW'(NUM - 1)) ? '0 : k + CW'(1);
            else      buf_raddr = k;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IO_IDLE;
         k         <= '0;
         cmd_q     <= NOP;
         command   <= NOP;
         s_ready_q <= 1'b0;
         m_valid_q <= 1'b0;
      end else begin
         case (state)
            IO_IDLE: begin
               if (start) begin
                  cmd_q     <= cmd_sel;
                  s_ready_q <= 1'b1;
                  k         <= '0;
                  state     <= IO_LOAD;
               end
            end
            IO_LOAD: begin
               if (s.valid) begin
                  if (k == CW'(NUM - 1)) begin
                     s_ready_q <= 1'b0;
                     command   <= cmd_q;
                     k         <= '0;
                     state     <= IO_ISSUE;
                  end else begin
                     k <= k + CW'(1);
                  end
               end
            end
            IO_ISSUE: begin
               command <= NOP;
               k       <= '0;
               state   <= IO_SHIFT;
            end
            IO_SHIFT: begin
               // The extra cycle after the window prefetches entry 0 for DRAIN.
               if (k == CW'(NUM + 1)) begin
                  m_valid_q <= 1'b1;
                  k         <= '0;
                  state     <= IO_DRAIN;
               end else begin
                  k <= k + CW'(1);
               end
            end
            IO_DRAIN: begin
               if (m.ready) begin
                  if (k == CW'(NUM - 1)) begin
                     m_valid_q <= 1'b0;
                     k         <= '0;
                     state     <= IO_IDLE;
                  end else begin
                     k <= k + CW'(1);
                  end
               end
            end
            default: begin
               state <= IO_IDLE;
               k     <= '0;
            end
         endcase
      end
   end

   replica_io_buf #(.NUM(NUM), .AW(CW)) u_buf (
      .clk   (clk),
      .we    (buf_we),
      .waddr (buf_waddr),
      .wdata (buf_wdata),
      .raddr (buf_raddr),
      .rdata (buf_rdata)
   );

endmodule
